// File: rtl/pixel_frame_writer.sv
// Captures one MAX_ROW x MAX_COL frame from a valid-only pixel stream into a
// double-banked frame buffer, then hands the finished bank to the display side.
module pixel_frame_writer #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540,
  parameter int OFF_W   = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_start_i,
  input  logic [7:0]       pixel_i,
  input  logic             pixel_en_i,
  output logic             wr_en_o,
  output logic [OFF_W:0]   wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             disp_bank_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [9:0]       cnt_row_o,
  output logic [9:0]       cnt_col_o
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

  localparam logic [9:0] LAST_ROW = 10'(MAX_ROW - 1);
  localparam logic [9:0] LAST_COL = 10'(MAX_COL - 1);

  state_e             state_q, state_d;
  logic [9:0]         row_q, row_d;
  logic [9:0]         col_q, col_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic               wr_bank_q, wr_bank_d;
  logic               wr_en_q, wr_en_d;
  logic [OFF_W:0]     wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;

  logic accept, last_px;

  // A restart request wins over a pixel arriving in the same cycle.
  assign accept  = (state_q == CAPTURE) && pixel_en_i && !capture_start_i;
  assign last_px = accept && (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_start_i) state_d = CAPTURE;
      CAPTURE: if (last_px)         state_d = DONE;
      DONE:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    off_d        = off_q;
    wr_bank_d    = wr_bank_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (capture_start_i) begin
          row_d     = '0;
          col_d     = '0;
          off_d     = '0;
          overrun_d = 1'b0;
        end else if (pixel_en_i) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (capture_start_i) begin
          row_d = '0;
          col_d = '0;
          off_d = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, off_q};
          wr_data_d = pixel_i;
          // Counters wrap to zero on the last pixel so the offset never leaves the frame.
          if (last_px) begin
            row_d = '0;
            col_d = '0;
            off_d = '0;
          end else begin
            off_d = off_q + OFF_W'(1);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 10'd1;
            end else begin
              col_d = col_q + 10'd1;
            end
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        wr_bank_d    = ~wr_bank_q;
        row_d        = '0;
        col_d        = '0;
        off_d        = '0;
        if (pixel_en_i) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      off_q        <= '0;
      wr_bank_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      off_q        <= off_d;
      wr_bank_q    <= wr_bank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign disp_bank_o  = ~wr_bank_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = overrun_q;
  assign cnt_row_o    = row_q;
  assign cnt_col_o    = col_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench: small 4x3 frame instance plus a wide-row instance for the long-row boundary.
module tb_pixel_frame_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance: 4 rows x 3 cols
  logic       cap, pen;
  logic [7:0] pix;
  logic       wr_en, disp_bank, frame_done, busy, overrun;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [9:0] cnt_row, cnt_col;

  pixel_frame_writer #(.MAX_ROW(4), .MAX_COL(3), .OFF_W(4)) dut (
    .clk(clk), .rst(rst), .capture_start_i(cap), .pixel_i(pix), .pixel_en_i(pen),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .disp_bank_o(disp_bank),
    .frame_done_o(frame_done), .busy_o(busy), .overrun_o(overrun),
    .cnt_row_o(cnt_row), .cnt_col_o(cnt_col)
  );

  // Wide instance: 540-pixel rows, 8 rows
  logic        cap2, pen2;
  logic [7:0]  pix2;
  logic        wr_en2, disp_bank2, frame_done2, busy2, overrun2;
  logic [13:0] wr_addr2;
  logic [7:0]  wr_data2;
  logic [9:0]  cnt_row2, cnt_col2;

  pixel_frame_writer #(.MAX_ROW(8), .MAX_COL(540), .OFF_W(13)) dut2 (
    .clk(clk), .rst(rst), .capture_start_i(cap2), .pixel_i(pix2), .pixel_en_i(pen2),
    .wr_en_o(wr_en2), .wr_addr_o(wr_addr2), .wr_data_o(wr_data2), .disp_bank_o(disp_bank2),
    .frame_done_o(frame_done2), .busy_o(busy2), .overrun_o(overrun2),
    .cnt_row_o(cnt_row2), .cnt_col_o(cnt_col2)
  );

  int errors = 0;
  int checks = 0;
  int wcount2 = 0;
  logic [13:0] last_addr2 = '0;

  always @(negedge clk) begin
    if (wr_en2) begin
      wcount2++;
      last_addr2 = wr_addr2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cap = 0; pen = 0; pix = 0; cap2 = 0; pen2 = 0; pix2 = 0;
    step(); step();
    // Reset state
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt", {cnt_row, cnt_col}, 0);
    chk("rst_disp", disp_bank, 1);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Frame 1: back-to-back pixels into bank 0
    cap = 1; step(); cap = 0;
    chk("f1_busy", busy, 1);
    chk("f1_cnt0", {cnt_row, cnt_col}, 0);
    for (int i = 0; i < 12; i++) begin
      pen = 1; pix = 8'(i); step();
      chk("f1_wr_en", wr_en, 1);
      chk("f1_addr", wr_addr, i);
      chk("f1_data", wr_data, i);
      if (i == 2) chk("f1_row1col0", {cnt_row, cnt_col}, {10'd1, 10'd0});
      if (i < 11) chk("f1_no_done", frame_done, 0);
    end
    pen = 0;
    chk("f1_done_state_busy", busy, 1);
    step();
    chk("f1_done", frame_done, 1);
    chk("f1_disp", disp_bank, 0);
    chk("f1_idle", busy, 0);
    chk("f1_cnt_clr", {cnt_row, cnt_col}, 0);
    chk("f1_no_wr", wr_en, 0);
    step();
    chk("f1_done_pulse", frame_done, 0);

    // Frame 2: pixel_en toggled, bank 1
    cap = 1; step(); cap = 0;
    for (int i = 0; i < 12; i++) begin
      pen = 1; pix = 8'(8'h20 + i); step();
      chk("f2_wr_en", wr_en, 1);
      chk("f2_addr", wr_addr, 5'h10 + i);
      chk("f2_data", wr_data, 8'h20 + i);
      pen = 0; step();
      chk("f2_gap_no_wr", wr_en, 0);
      chk("f2_done", frame_done, (i == 11) ? 1 : 0);
    end
    step();
    chk("f2_done_pulse", frame_done, 0);
    chk("f2_disp", disp_bank, 1);
    chk("f2_overrun", overrun, 0);

    // Overrun in IDLE
    pen = 1; step();
    chk("ov_set1", overrun, 1);
    chk("ov_no_wr1", wr_en, 0);
    step();
    chk("ov_set2", overrun, 1);
    chk("ov_no_wr2", wr_en, 0);
    pen = 0; cap = 1; step(); cap = 0;
    chk("ov_clear", overrun, 0);
    chk("ov_busy", busy, 1);

    // Restart mid-frame (bank 0 again)
    for (int i = 0; i < 5; i++) begin
      pen = 1; pix = 8'(8'h40 + i); step();
      chk("rs_addr", wr_addr, i);
    end
    chk("rs_cnt5", {cnt_row, cnt_col}, {10'd1, 10'd2});
    cap = 1; pen = 1; pix = 8'hAA; step(); cap = 0;
    chk("rs_dropped", wr_en, 0);
    chk("rs_cnt_clr", {cnt_row, cnt_col}, 0);
    chk("rs_no_done", frame_done, 0);
    chk("rs_busy", busy, 1);
    pix = 8'h55; step();
    chk("rs_addr0", wr_addr, 0);
    chk("rs_data", wr_data, 8'h55);
    pix = 8'h56; step();
    pix = 8'h57; step();
    pen = 0;
    chk("rs_cnt3", {cnt_row, cnt_col}, {10'd1, 10'd0});

    // Asynchronous reset mid-capture
    #2 rst = 1'b1;
    #1;
    chk("ar_wr_en", wr_en, 0);
    chk("ar_addr", wr_addr, 0);
    chk("ar_data", wr_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", {cnt_row, cnt_col}, 0);
    chk("ar_disp", disp_bank, 1);
    chk("ar_done", frame_done, 0);
    step();
    rst = 1'b0;
    step();
    chk("ar_idle", busy, 0);
    pen = 1; step(); pen = 0;
    chk("ar_idle_overrun", overrun, 1);
    chk("ar_idle_no_wr", wr_en, 0);

    // Wide instance: full frame with 540-pixel rows
    cap2 = 1; step(); cap2 = 0;
    for (int i = 0; i < 8 * 540; i++) begin
      pen2 = 1; pix2 = 8'(i); step();
      if (i == 538) chk("w_col539", {cnt_row2, cnt_col2}, {10'd0, 10'd539});
      if (i == 539) chk("w_row_wrap", {cnt_row2, cnt_col2}, {10'd1, 10'd0});
    end
    pen2 = 0;
    begin
      int n;
      n = 0;
      while (frame_done2 !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      chk("w_done_seen", frame_done2, 1);
    end
    step();
    chk("w_writes", wcount2, 8 * 540);
    chk("w_last_addr", last_addr2, 14'd4319);
    chk("w_disp", disp_bank2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
